axi_lite_bresp_arbiter: RTL and testbench
=========================================

Name: axi_lite_bresp_arbiter

Overview:
Shares one AXI4-Lite master-side write response (B) channel among NUM_SRC slave-side response sources, such as multiple write-response slaves behind an interconnect. Grants are round-robin. The accepted response is held in an output register that stays stable until BREADY. The block also returns the source index with each response and keeps a saturating count of error responses (SLVERR/DECERR).

Parameters:
NUM_SRC, 4, number of response sources (2..8)
SRC_W, 2, width of source index; must be >= clog2(NUM_SRC)
CNT_W, 16, width of error counter

Ports:
ACLK  input  1  clock, rising edge
ARESETn  input  1  reset, asynchronous, active-high
s_bvalid  input  NUM_SRC  per-source response valid
s_bresp  input  2*NUM_SRC  per-source BRESP; source k occupies bits [2k+1:2k]
s_bready  output  NUM_SRC  per-source accept strobe, one-hot or zero
m_bvalid  output  1  master-side BVALID
m_bready  input  1  master-side BREADY
m_bresp  output  2  registered BRESP of the held response
m_bsrc  output  SRC_W  index of the source that produced the held response
err_cnt  output  CNT_W  count of accepted responses with BRESP[1]=1
err_clr  input  1  synchronous clear of err_cnt
busy  output  1  equals m_bvalid

Behaviour:
- Reset is decided: ARESETn, asynchronous, active-high; clock ACLK. While ARESETn=1, all state clears immediately, independent of ACLK:
  - m_bvalid=0, m_bresp=0, m_bsrc=0, err_cnt=0, state=IDLE.
  - Last-grant pointer = NUM_SRC-1, so source 0 has first priority after reset.
  - s_bready=0 because it is gated by reset.
- A response held when reset asserts is dropped. Sources must re-present.
- FSM states: IDLE (holding register empty) and HOLD (m_bvalid=1).
- Accept window: `accept = (state==IDLE) | (state==HOLD & m_bready)`.
- Grant: when accept=1 and any s_bvalid=1, pick the first requesting source scanning upward from (last_grant+1) mod NUM_SRC. Drive s_bready[g]=1 combinationally in that cycle; all other bits stay 0.
- On the clock edge where s_bready[g]=1:
  - m_bresp <= s_bresp[g], m_bsrc <= g, m_bvalid <= 1, last_grant <= g.
  - Next state = HOLD.
- Transitions:
  - HOLD with m_bready=1 and no request: m_bvalid <= 0, go to IDLE.
  - HOLD with m_bready=1 and a request: load the new response the same cycle. m_bvalid stays 1 (back-to-back, one response per cycle).
  - HOLD with m_bready=0: m_bresp, m_bsrc and m_bvalid hold exactly; s_bready=0.
- Latency: a source asserting s_bvalid in IDLE gets s_bready in the same cycle; m_bvalid rises at the next edge.
- Fairness: a continuously requesting source waits at most NUM_SRC-1 grants.
- Sources follow AXI rules: s_bvalid, once high, stays high with stable s_bresp until s_bready. The arbiter does not check this.
- s_bready never depends on s_bvalid of a non-granted source. It must not depend on m_bready when state==IDLE.
- Error counter: increments by 1 on each grant whose BRESP[1]=1 (2'b10 SLVERR, 2'b11 DECERR).
  - Saturates at all-ones.
  - err_clr=1 sets it to 0 at the next edge and takes priority over a simultaneous increment.
- Single-source case: when only one source requests, its repeated responses stream at one per cycle while m_bready=1.

Test Plan:
- Reset then single request: s_bvalid=4'b0100, s_bresp[5:4]=2'b00, m_bready=1 → s_bready=4'b0100 in cycle t; at t+1 m_bvalid=1, m_bresp=0, m_bsrc=2; at t+2 m_bvalid=0.
- Backpressure: src1 sends BRESP=2'b10 with m_bready=0 for 5 cycles → m_bvalid, m_bresp=2 and m_bsrc=1 stay stable all 5 cycles; s_bready=0 throughout; then m_bready=1 for 1 cycle → m_bvalid drops; err_cnt=1.
- Round-robin: all 4 sources request continuously, m_bready=1 → grant order 0,1,2,3,0,1; m_bvalid high every cycle after the first; no source is granted twice before the others.
- Simultaneous clear and error: err_cnt=5, grant with BRESP=2'b11 in the same cycle as err_clr=1 → err_cnt=0 next cycle. Saturation check: force 65535+2 errors → err_cnt=16'hFFFF.
- Reset mid-operation: assert ARESETn while in HOLD with m_bready=0 → m_bvalid=0 and m_bsrc=0 immediately, with no clock edge; after release with sources 0 and 3 requesting, source 0 is granted first.

Source files
------------

// File: rtl/axi_lite_bresp_arbiter.sv
// axi_lite_bresp_arbiter: round-robin merge of NUM_SRC write-response sources onto one AXI4-Lite B channel,
// with a held output register, source tagging and a saturating error-response counter.
module axi_lite_bresp_arbiter #(
    parameter int NUM_SRC = 4,
    parameter int SRC_W   = 2,
    parameter int CNT_W   = 16
) (
    input  logic                 ACLK,
    input  logic                 ARESETn,
    input  logic [NUM_SRC-1:0]   s_bvalid,
    input  logic [2*NUM_SRC-1:0] s_bresp,
    output logic [NUM_SRC-1:0]   s_bready,
    output logic                 m_bvalid,
    input  logic                 m_bready,
    output logic [1:0]           m_bresp,
    output logic [SRC_W-1:0]     m_bsrc,
    output logic [CNT_W-1:0]     err_cnt,
    input  logic                 err_clr,
    output logic                 busy
);
    typedef enum logic {IDLE, HOLD} state_t;

    state_t             state_q, state_d;
    logic [1:0]         bresp_q, bresp_d;
    logic [SRC_W-1:0]   src_q, src_d;
    logic [SRC_W-1:0]   last_q, last_d;
    logic [CNT_W-1:0]   err_q, err_d;
    logic [SRC_W-1:0]   idx, gnt;
    logic [1:0]         gresp;
    logic               found, accept, take;

    always_comb begin
        found = 1'b0;
        gnt   = '0;
        gresp = '0;
        idx   = '0;
        // first requester at or after last_grant+1, wrapping at NUM_SRC
        for (int i = 0; i < NUM_SRC; i++) begin
            idx = SRC_W'((int'(last_q) + 1 + i) % NUM_SRC);
            if (!found && s_bvalid[idx]) begin
                found = 1'b1;
                gnt   = idx;
                gresp = s_bresp[{idx, 1'b0} +: 2];
            end
        end
        accept   = (state_q == IDLE) || m_bready;
        take     = accept && found && !ARESETn;
        s_bready = take ? (NUM_SRC'(1) << gnt) : '0;
        state_d  = take ? HOLD : (state_q == HOLD && m_bready) ? IDLE : state_q;
        bresp_d  = take ? gresp : bresp_q;
        src_d    = take ? gnt : src_q;
        last_d   = take ? gnt : last_q;
        err_d    = err_clr ? '0 : (take && gresp[1] && !(&err_q)) ? err_q + CNT_W'(1) : err_q;
    end

    always_ff @(posedge ACLK or posedge ARESETn) begin
        if (ARESETn) begin
            state_q <= IDLE;
            bresp_q <= '0;
            src_q   <= '0;
            last_q  <= SRC_W'(NUM_SRC - 1);
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            bresp_q <= bresp_d;
            src_q   <= src_d;
            last_q  <= last_d;
            err_q   <= err_d;
        end
    end

    assign m_bvalid = (state_q == HOLD);
    assign busy     = m_bvalid;
    assign m_bresp  = bresp_q;
    assign m_bsrc   = src_q;
    assign err_cnt  = err_q;
endmodule

// File: tb/tb_axi_lite_bresp_arbiter.sv
// tb_axi_lite_bresp_arbiter: directed and random checks of the B-channel arbiter against a
// cycle-level model of holding register, round-robin pointer and error count.
module tb_axi_lite_bresp_arbiter;
    logic        ACLK = 1'b0;
    logic        ARESETn = 1'b1;
    logic [3:0]  s_bvalid = '0;
    logic [7:0]  s_bresp = '0;
    logic [3:0]  s_bready;
    logic        m_bvalid, m_bready = 1'b1, err_clr = 1'b0, busy;
    logic [1:0]  m_bresp;
    logic [1:0]  m_bsrc;
    logic [15:0] err_cnt;

    int total = 0, bad = 0;
    int m_last, m_src, m_err;
    bit m_valid;
    logic [1:0] m_resp;
    logic [3:0] exp_rdy, obs_rdy;

    axi_lite_bresp_arbiter #(.NUM_SRC(4), .SRC_W(2), .CNT_W(16)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn), .s_bvalid(s_bvalid), .s_bresp(s_bresp),
        .s_bready(s_bready), .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
        .m_bsrc(m_bsrc), .err_cnt(err_cnt), .err_clr(err_clr), .busy(busy)
    );

    always #5 ACLK = ~ACLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 0; m_resp = 0; m_src = 0; m_err = 0; m_last = 3;
    endtask

    function automatic int pick();
        int g = -1;
        for (int i = 0; i < 4; i++) begin
            int k = (m_last + 1 + i) % 4;
            if (g < 0 && s_bvalid[k]) g = k;
        end
        return g;
    endfunction

    // one clock: check at the falling edge, then advance the model to the rising edge
    task automatic cyc();
        int g;
        logic [1:0] r;
        @(negedge ACLK);
        g = (!m_valid || m_bready) ? pick() : -1;
        exp_rdy = (g >= 0) ? 4'(1 << g) : 4'd0;
        obs_rdy = s_bready;
        chk("s_bready", s_bready, exp_rdy);
        chk("m_bvalid", m_bvalid, m_valid);
        chk("busy", busy, m_valid);
        chk("m_bresp", m_bresp, m_resp);
        chk("m_bsrc", m_bsrc, m_src);
        chk("err_cnt", err_cnt, m_err);
        r = (g >= 0) ? s_bresp[2*g +: 2] : 2'b00;
        if (err_clr) m_err = 0;
        else if (g >= 0 && r[1] && m_err < 65535) m_err++;
        if (g >= 0) begin
            m_valid = 1; m_resp = r; m_src = g; m_last = g;
        end else if (m_bready) m_valid = 0;
        @(posedge ACLK);
        #1;
    endtask

    task automatic do_reset();
        ARESETn = 1'b1;
        model_reset();
        @(posedge ACLK);
        #1;
        ARESETn = 1'b0;
    endtask

    initial begin
        logic [3:0] order [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
        model_reset();
        s_bvalid = 4'b1111;
        #2;
        chk("rst_bready", s_bready, 0);
        chk("rst_bvalid", m_bvalid, 0);
        chk("rst_bsrc", m_bsrc, 0);
        chk("rst_err", err_cnt, 0);
        s_bvalid = '0;
        @(posedge ACLK);
        #1;
        ARESETn = 1'b0;

        // single request from source 2
        s_bvalid = 4'b0100; s_bresp = 8'h00; m_bready = 1'b1;
        cyc();
        chk("single_rdy", obs_rdy, 4'b0100);
        s_bvalid = '0;
        cyc();
        chk("single_src", m_bsrc, 2);
        cyc();
        chk("single_drop", m_bvalid, 0);

        // backpressure with SLVERR from source 1
        s_bvalid = 4'b0010; s_bresp = 8'b0000_1000; m_bready = 1'b0;
        cyc();
        s_bvalid = '0;
        repeat (5) cyc();
        m_bready = 1'b1;
        cyc();
        cyc();
        chk("bp_err_one", err_cnt, 1);

        // round robin from reset
        do_reset();
        s_bvalid = 4'b1111; s_bresp = 8'h00;
        for (int i = 0; i < 6; i++) begin
            cyc();
            chk("rr_order", obs_rdy, order[i]);
        end
        s_bvalid = '0;
        cyc();

        // clear wins over a simultaneous error
        do_reset();
        s_bvalid = 4'b0001; s_bresp = 8'b0000_0010;
        repeat (5) cyc();
        s_bresp = 8'b0000_0011; err_clr = 1'b1;
        cyc();
        chk("clr_pre", obs_rdy, 4'b0001);
        err_clr = 1'b0; s_bvalid = '0;
        cyc();
        chk("clr_wins", err_cnt, 0);

        // saturation
        s_bvalid = 4'b0001; s_bresp = 8'b0000_0010;
        repeat (65537) cyc();
        s_bvalid = '0;
        cyc();
        chk("saturate", err_cnt, 16'hFFFF);

        // reset while holding, with no clock edge
        do_reset();
        s_bvalid = 4'b1000; s_bresp = 8'b0100_0000; m_bready = 1'b0;
        cyc();
        s_bvalid = '0;
        cyc();
        s_bvalid = 4'b1001;
        ARESETn = 1'b1;
        #1;
        chk("async_bvalid", m_bvalid, 0);
        chk("async_bsrc", m_bsrc, 0);
        chk("async_bready", s_bready, 0);
        model_reset();
        ARESETn = 1'b0;
        m_bready = 1'b1;
        cyc();
        chk("post_rst_first", obs_rdy, 4'b0001);

        // random traffic obeying source handshake rules
        for (int n = 0; n < 400; n++) begin
            m_bready = ($urandom_range(0, 3) != 0);
            err_clr = ($urandom_range(0, 31) == 0);
            cyc();
            for (int k = 0; k < 4; k++) begin
                if (exp_rdy[k] || !s_bvalid[k]) begin
                    s_bvalid[k] = 1'($urandom_range(0, 1));
                    s_bresp[2*k +: 2] = 2'($urandom);
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
